date_checker: RTL and testbench



---
 rtl/date_pkg.sv | 27 ++
 rtl/date_checker_if.sv | 8 +
 rtl/date_validator.sv | 60 ++++++
 rtl/date_checker.sv | 32 +++
 tb/tb_date_checker.sv | 93 +++++++++
 5 files changed

// File: rtl/date_pkg.sv
// Shared constants and helpers for the streaming YYYY-MM-DD date recogniser.
// The window is packed oldest-first: byte i of the vector is character position i.
package date_pkg;

    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam int         WIN_LEN    = 10;
    localparam int         WIN_W      = WIN_LEN * 8;

    typedef enum logic [1:0] {
        MON_31  = 2'd0,
        MON_30  = 2'd1,
        MON_FEB = 2'd2,
        MON_BAD = 2'd3
    } month_kind_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

    // Only meaningful for bytes already known to be ASCII digits (low nibble = value).
    function automatic logic [6:0] two_digit(input logic [7:0] hi, input logic [7:0] lo);
        return 7'(hi[3:0]) * 7'd10 + 7'(lo[3:0]);
    endfunction

endpackage

// File: rtl/date_checker_if.sv
// Character stream in, match flag out.
interface date_checker_if;
    logic [7:0] in;
    logic       valid;

    modport master (output in, input valid);
    modport slave  (input in, output valid);
endinterface

// File: rtl/date_validator.sv
// Purely combinational check that a 10-character window is a real Gregorian
// date: format, month range, day range per month, and the leap-year rule.
module date_validator
    import date_pkg::*;
(
    input  logic [WIN_W-1:0] window_i,
    output logic             ok_o
);

    logic [7:0]         ch [WIN_LEN];
    logic [WIN_LEN-1:0] fmt_ok;

    generate
        for (genvar gi = 0; gi < WIN_LEN; gi++) begin : g_pos
            assign ch[gi] = window_i[8*gi +: 8];
            if (gi == 4 || gi == 7) begin : g_dash
                assign fmt_ok[gi] = (ch[gi] == ASCII_DASH);
            end else begin : g_digit
                assign fmt_ok[gi] = is_digit(ch[gi]);
            end
        end
    endgenerate

    logic [6:0]  year_hi, year_lo, month, day;
    logic        leap;
    month_kind_e kind;
    logic [6:0]  max_day;

    assign year_hi = two_digit(ch[0], ch[1]);
    assign year_lo = two_digit(ch[2], ch[3]);
    assign month   = two_digit(ch[5], ch[6]);
    assign day     = two_digit(ch[8], ch[9]);

    // A century year is leap only when its century number is a multiple of 4.
    assign leap = (year_lo != 7'd0) ? (year_lo[1:0] == 2'b00)
                                    : (year_hi[1:0] == 2'b00);

    always_comb begin
        kind = MON_BAD;
        case (month)
            7'd1, 7'd3, 7'd5, 7'd7, 7'd8, 7'd10, 7'd12: kind = MON_31;
            7'd4, 7'd6, 7'd9, 7'd11:                    kind = MON_30;
            7'd2:                                       kind = MON_FEB;
            default:                                    kind = MON_BAD;
        endcase
    end

    always_comb begin
        max_day = 7'd0;
        case (kind)
            MON_31:  max_day = 7'd31;
            MON_30:  max_day = 7'd30;
            MON_FEB: max_day = leap ? 7'd29 : 7'd28;
            default: max_day = 7'd0;
        endcase
    end

    assign ok_o = (&fmt_ok) && (kind != MON_BAD) && (day != 7'd0) && (day <= max_day);

endmodule

// File: rtl/date_checker.sv
// Ten-byte character shift window feeding the date validator; valid is a
// function of the registered window only, so the input has no path to it.
module date_checker
    import date_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    date_checker_if.slave  bus
);

    logic [WIN_W-1:0] window_q, window_d;
    logic             ok;

    // Newest character enters at the top byte (position 9); oldest drops off byte 0.
    assign window_d = {bus.in, window_q[WIN_W-1:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

    date_validator u_validator (
        .window_i (window_q),
        .ok_o     (ok)
    );

    assign bus.valid = ok;

endmodule

// File: tb/tb_date_checker.sv
// Directed-vector bench for date_checker: each string is streamed one char per
// clock and valid is checked after every edge against hand-computed positions.
module tb_date_checker;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    date_checker_if bus ();

    date_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic expected);
        total++;
        assert (bus.valid === expected)
        else begin
            bad++;
            $error("FAIL %s valid=%0b expected=%0b", tag, bus.valid, expected);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset  = 1'b1;
        bus.in = 8'h00;
        repeat (cycles) @(posedge clk);
        #1;
        check("reset", 1'b0);
        reset = 1'b0;
    endtask

    // p1/p2: 1-based char positions after which valid must be 1 (0 = unused).
    task automatic send_str(input string s, input int p1, input int p2);
        logic exp_v;
        for (int i = 0; i < s.len(); i++) begin
            bus.in = s[i];
            @(posedge clk);
            #1;
            exp_v = ((i + 1) == p1) || ((i + 1) == p2);
            check($sformatf("%s[%0d]", s, i + 1), exp_v);
        end
        $display("sent \"%s\" expect_hi_at=%0d,%0d", s, p1, p2);
    endtask

    initial begin
        bus.in = 8'h00;

        do_reset(2);
        send_str("2012-02222-12-2521-12-12", 16, 24);

        do_reset(1); send_str("2000-02-29", 10, 0);
        do_reset(1); send_str("1900-02-29",  0, 0);
        do_reset(1); send_str("2024-02-29", 10, 0);
        do_reset(1); send_str("2023-02-29",  0, 0);
        do_reset(1); send_str("2023-02-28", 10, 0);
        do_reset(1); send_str("0000-02-29", 10, 0);

        do_reset(1); send_str("2021-04-31",  0, 0);
        do_reset(1); send_str("2021-04-30", 10, 0);
        do_reset(1); send_str("2021-12-31", 10, 0);
        do_reset(1); send_str("2021-13-01",  0, 0);
        do_reset(1); send_str("2021-00-10",  0, 0);
        do_reset(1); send_str("2021-05-00",  0, 0);
        do_reset(1); send_str("2021-01-32",  0, 0);

        do_reset(1); send_str("2021/01/01",  0, 0);
        do_reset(1); send_str("2021-1-011",  0, 0);
        do_reset(1); send_str("20a1-01-01",  0, 0);

        // Mid-stream reset must discard the partial date.
        do_reset(1);
        send_str("2021-06-1", 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset", 1'b0);
        reset = 1'b0;
        send_str("5", 0, 0);
        send_str("2021-06-15", 10, 0);

        do_reset(1); send_str("2020-01-012020-01-02", 10, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
